// File: rtl/mmio_port_controller.sv
// Memory-mapped I/O port: output register, 2-flop synchronized and debounced
// 8-bit input, sticky change flag, and a status word, all decoded off the ALU address.
module mmio_port_controller #(
  parameter logic [31:0] OUT_ADDR        = 32'h1001_0024,
  parameter logic [31:0] IN_ADDR         = 32'h1001_0028,
  parameter logic [31:0] STATUS_ADDR     = 32'h1001_002C,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] OUT_RESET       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] IoReadData,
  output logic        IoHit,
  output logic        ChangeFlag,
  output logic [31:0] PortOut
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [31:0]   r_out;
  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [7:0]    r_cand;
  logic [7:0]    r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_flag;

  logic w_hit_out;
  logic w_hit_in;
  logic w_hit_status;
  logic w_pending;
  logic w_accept;

  assign w_hit_out    = (Address == OUT_ADDR);
  assign w_hit_in     = (Address == IN_ADDR);
  assign w_hit_status = (Address == STATUS_ADDR);
  assign w_pending    = (r_cand != r_stable);
  // Acceptance needs the candidate unchanged this edge and its full hold count reached.
  assign w_accept     = (r_sync2 == r_cand) && w_pending && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= OUT_RESET;
    end else if (MemWrite && w_hit_out) begin
      r_out <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= PortIn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_stable <= r_cand;
      r_cnt    <= '0;
    end else if (w_pending) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // A new acceptance on the same edge as a clearing load keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flag <= 1'b0;
    end else if (w_accept) begin
      r_flag <= 1'b1;
    end else if (MemRead && w_hit_in) begin
      r_flag <= 1'b0;
    end
  end

  always_comb begin
    IoReadData = '0;
    if (w_hit_out) begin
      IoReadData = r_out;
    end else if (w_hit_in) begin
      IoReadData = {24'b0, r_stable};
    end else if (w_hit_status) begin
      IoReadData = {30'b0, w_pending, r_flag};
    end
  end

  assign IoHit      = w_hit_out | w_hit_in | w_hit_status;
  assign ChangeFlag = r_flag;
  assign PortOut    = r_out;

endmodule

// File: doc/mmio_port_controller.md
Name: mmio_port_controller

Overview:
- Memory-mapped I/O stage directly downstream of the processor's ALU result and store-data path. It drives the external PortOut and samples the external 8-bit PortIn.
- It decodes the data address (ALU result), latches store data into an output register and returns synchronized, debounced input plus a sticky change flag on loads.
- A hit signal tells the processor's memory-or-ALU writeback mux to take IoReadData instead of data RAM.

Parameters:
- OUT_ADDR, 32'h1001_0024, word address of the output register (R/W).
- IN_ADDR, 32'h1001_0028, word address of the debounced input (RO; a read clears the change flag).
- STATUS_ADDR, 32'h1001_002C, word address of the status register (RO).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before an input change is accepted; legal range 1..65535.
- OUT_RESET, 32'h0000_0000, reset value of the output register.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  data address (ALU result).
- WriteData  input  32  store data (register file ReadData2).
- MemWrite  input  1  store strobe from control.
- MemRead  input  1  load strobe from control.
- PortIn  input  8  asynchronous external input pins.
- IoReadData  output  32  combinational load data.
- IoHit  output  1  combinational; 1 when Address equals any of the three addresses.
- ChangeFlag  output  1  sticky flag: debounced input has changed.
- PortOut  output  32  output register value.

Behaviour:
- Reset (reset=0, async): out_reg=OUT_RESET, sync1=sync2=cand=stable=8'h00, cnt=0, flag=0. Therefore PortOut=OUT_RESET and ChangeFlag=0. IoReadData and IoHit follow Address combinationally.
- Decode: exact 32-bit compare, so Address[1:0] must be 00. Unaligned or non-matching addresses give IoHit=0 and IoReadData=0.
- Output write: at a posedge with MemWrite=1 and Address==OUT_ADDR, out_reg<=WriteData. PortOut updates after that edge (1-cycle latency). Writes to IN_ADDR, STATUS_ADDR or unmapped addresses are ignored.
- Read mux (combinational, independent of MemRead):
  - OUT_ADDR returns out_reg.
  - IN_ADDR returns {24'b0, stable}.
  - STATUS_ADDR returns {23'b0, cnt!=0, stable!=cand... } is not used; the defined value is {30'b0, cand!=stable, flag}.
  - Any other address returns 0.
- Synchronizer: two flops, sync1<=PortIn, sync2<=sync1, every edge.
- Debounce, evaluated each posedge in priority order:
  - (a) sync2!=cand: cand<=sync2, cnt<=0.
  - (b) cand!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=cand, cnt<=0, flag<=1.
  - (c) cand!=stable: cnt<=cnt+1.
  - (d) otherwise: cnt<=0.
  - cnt width is clog2(DEBOUNCE_CYCLES), minimum 1 bit. cnt never wraps because it resets at DEBOUNCE_CYCLES-1.
- Latency: a PortIn value first sampled into sync1 at edge k appears on stable after edge k+2+DEBOUNCE_CYCLES, provided it is held. A glitch shorter than DEBOUNCE_CYCLES+1 cycles at sync2 never reaches stable.
- Bounce back: if the input returns to the current stable value mid-count, rule (a) reloads cand, then rule (d) clears cnt. No flag is raised.
- Flag clear: at a posedge with MemRead=1 and Address==IN_ADDR, flag<=0. If rule (b) fires on the same edge, set wins and flag stays 1. The load returns the pre-edge stable value.
- MemRead and MemWrite both 1: the write and the read-clear each act independently per their own address match.
- Reset asserted mid-debounce discards the count. After release the debounce restarts from stable=0.

Test Plan:
- Reset low, then release; read OUT_ADDR, IN_ADDR and STATUS_ADDR -> 32'h0, 32'h0, 32'h0; IoHit=1 for each; Address=32'h1001_0030 -> IoHit=0, data 0.
- MemWrite=1, Address=OUT_ADDR, WriteData=32'hDEAD_BEEF for one cycle -> PortOut=32'hDEAD_BEEF after that edge. Write 32'h1234 to IN_ADDR -> PortOut unchanged, IN read still 0.
- DEBOUNCE_CYCLES=4: PortIn=8'hA5 sampled at edge 1 and held -> stable=8'hA5 and ChangeFlag=1 after edge 7, not earlier. STATUS reads 32'h2 during edges 3..6, then 32'h1.
- Glitch: PortIn=8'h01 for 3 cycles, then back to 8'h00 -> stable stays 8'h00, ChangeFlag stays 0.
- Set-vs-clear collision: with flag=1, perform a load of IN_ADDR on the same edge a new value (8'h3C) is accepted -> ChangeFlag remains 1. The next IN_ADDR load clears it to 0 and returns 32'h3C.
- Assert reset during an in-progress debounce (cnt=2) -> all outputs return to reset values immediately and asynchronously. The debounce restarts from zero after release.
